// File: rtl/riscv_uart_programmer_pkg.sv
// Shared encodings for the UART programmer: frame FSM states and frame geometry.
// Latency: n/a (constants only).  Backpressure: n/a.
package riscv_uart_programmer_pkg;

  localparam logic [2:0] UPG_ST_IDLE = 3'd0;
  localparam logic [2:0] UPG_ST_HDR0 = 3'd1;
  localparam logic [2:0] UPG_ST_HDR1 = 3'd2;
  localparam logic [2:0] UPG_ST_DATA = 3'd3;
  localparam logic [2:0] UPG_ST_DONE = 3'd4;
  localparam logic [2:0] UPG_ST_ERR  = 3'd5;
  localparam logic [2:0] UPG_ST_CSUM = 3'd6;

  localparam int UPG_HDR_BYTES  = 2;
  localparam int UPG_WORD_BYTES = 4;

endpackage

// File: rtl/riscv_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte_valid / frame_err.
// Latency: byte_valid one cycle after the mid-stop-bit sample.  Backpressure: none; byte is lost if unused.
module riscv_uart_rx #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          rx_m, rx_s, rx_d;
  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sh         <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_d       <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s) st <= RX_START;
        end
        RX_START: begin
          // A line that is high again at mid-start was only a glitch.
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            sh      <= {rx_s, sh[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_s) begin
              rx_byte    <= sh;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/riscv_uart_programmer.sv
// UART frame programmer: header N, then N little-endian words written as upg_* strobes (RISCV_UPG_CHECKSUM_EN adds an XOR trailer byte).
// Latency: write strobe one cycle after the 4th byte of a word.  Backpressure: none; the upg_* sink must accept every strobe.
module riscv_uart_programmer
  import riscv_uart_programmer_pkg::*;
#(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              upg_rst_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam int DIV_RAW = CLK_FREQ / BAUD;
  localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);
`ifdef RISCV_UPG_CHECKSUM_EN
  localparam logic [2:0] FRAME_END = UPG_ST_CSUM;
`else
  localparam logic [2:0] FRAME_END = UPG_ST_DONE;
`endif

  logic [7:0]                   rx_byte;
  logic                         byte_valid, frame_err;
  logic [2:0]                   state;
  logic [8*UPG_HDR_BYTES-1:0]   n_words;
  logic [8*UPG_HDR_BYTES-1:0]   n_next;
  logic [ADDR_W:0]              idx;
  logic [1:0]                   byte_idx;
  logic [31:0]                  word;
  logic [TW-1:0]                tcnt;
  logic                         timed_out;
`ifdef RISCV_UPG_CHECKSUM_EN
  logic [7:0]                   csum;
`endif

  riscv_uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // A byte landing on the expiry cycle wins over the timeout.
  assign timed_out  = (tcnt == TW'(TIMEOUT_CYC - 1)) && !byte_valid;
  assign n_next     = {rx_byte, n_words[7:0]};
  assign upg_rst_o  = (state != UPG_ST_DATA) && (state != UPG_ST_CSUM);
  assign upg_done_o = (state == UPG_ST_DONE);
  assign upg_err_o  = (state == UPG_ST_ERR);
  assign upg_adr_o  = idx[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UPG_ST_IDLE;
      n_words   <= '0;
      idx       <= '0;
      byte_idx  <= '0;
      word      <= '0;
      tcnt      <= '0;
      upg_wen_o <= 1'b0;
      upg_dat_o <= '0;
`ifdef RISCV_UPG_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      upg_wen_o <= 1'b0;
      if (frame_err) begin
        state <= UPG_ST_ERR;
      end else begin
        case (state)
          UPG_ST_IDLE, UPG_ST_HDR0, UPG_ST_DONE, UPG_ST_ERR: begin
            if (byte_valid) begin
              n_words[7:0] <= rx_byte;
              tcnt         <= '0;
              state        <= UPG_ST_HDR1;
            end
          end
          UPG_ST_HDR1: begin
            if (byte_valid) begin
              n_words[15:8] <= rx_byte;
              tcnt          <= '0;
              idx           <= '0;
              byte_idx      <= '0;
`ifdef RISCV_UPG_CHECKSUM_EN
              csum          <= '0;
`endif
              if (n_next == '0)                            state <= FRAME_END;
              else if (32'(n_next) > (32'd1 << ADDR_W))    state <= UPG_ST_ERR;
              else                                         state <= UPG_ST_DATA;
            end else if (timed_out) begin
              state <= UPG_ST_ERR;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          UPG_ST_DATA: begin
            // idx advances in the cycle after its strobe, so upg_adr_o is stable during the strobe.
            if (upg_wen_o) begin
              idx <= idx + 1'b1;
              if (32'(idx) + 32'd1 == 32'(n_words)) state <= FRAME_END;
            end
            if (byte_valid) begin
              word[8*byte_idx +: 8] <= rx_byte;
              byte_idx              <= byte_idx + 1'b1;
              tcnt                  <= '0;
`ifdef RISCV_UPG_CHECKSUM_EN
              csum                  <= csum ^ rx_byte;
`endif
              if (byte_idx == 2'(UPG_WORD_BYTES - 1)) begin
                upg_wen_o <= 1'b1;
                upg_dat_o <= {rx_byte, word[23:0]};
              end
            end else if (timed_out) begin
              state <= UPG_ST_ERR;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
`ifdef RISCV_UPG_CHECKSUM_EN
          UPG_ST_CSUM: begin
            if (byte_valid) begin
              state <= (rx_byte == csum) ? UPG_ST_DONE : UPG_ST_ERR;
            end else if (timed_out) begin
              state <= UPG_ST_ERR;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
`endif
          default: state <= UPG_ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_uart_programmer.sv
// Self-checking bench: serial frames driven bit by bit, expected writes and end state from a frame-level model.
module tb_riscv_uart_programmer;

  localparam int ADDR_W = 14;
  localparam int DIV    = 16;
  localparam int TO     = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx  = 1'b1;
  logic              upg_rst_o, upg_wen_o, upg_done_o, upg_err_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;

  riscv_uart_programmer #(
    .CLK_FREQ(16), .BAUD(1), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .upg_rst_o(upg_rst_o), .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o),
    .upg_dat_o(upg_dat_o), .upg_done_o(upg_done_o), .upg_err_o(upg_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every strobe must match the next expected write; idle/done/err must imply programming reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (upg_wen_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wen adr=%h dat=%h", upg_adr_o, upg_dat_o);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("wen_adr", 32'(upg_adr_o), 32'(w.adr));
          check("wen_dat", upg_dat_o, w.dat);
          check("wen_rst", 32'(upg_rst_o), 32'd0);
        end
      end
      check("rst_when_settled", 32'((upg_done_o | upg_err_o) & ~upg_rst_o), 32'd0);
    end
  end

  // Frame-level model: from the byte list (and the index of a byte with a bad stop bit, or -1)
  // derive which words get written and whether the frame ends done or in error.
  task automatic model_frame(input logic [7:0] b[$], input int bad_idx,
                             output bit exp_done, output bit exp_err);
    int avail, n, need;
    logic [7:0] x;
    exp_done = 0;
    exp_err  = 0;
    avail = (bad_idx >= 0) ? bad_idx : b.size();
    if (avail < 2) begin exp_err = 1; return; end
    n = int'(b[0]) + 256 * int'(b[1]);
    if (n > (1 << ADDR_W)) begin exp_err = 1; return; end
    for (int w = 0; w < n; w++) begin
      int p;
      p = 2 + 4 * w;
      if (p + 4 <= avail) begin
        wr_t e;
        e.adr = ADDR_W'(w);
        e.dat = {b[p+3], b[p+2], b[p+1], b[p]};
        exp_q.push_back(e);
      end
    end
    need = 2 + 4 * n;
`ifdef RISCV_UPG_CHECKSUM_EN
    x = 8'h00;
    for (int i = 2; i < need && i < avail; i++) x = x ^ b[i];
    if (avail >= need + 1) begin
      if (b[need] == x) exp_done = 1; else exp_err = 1;
    end else exp_err = 1;
`else
    x = 8'h00;
    if (avail >= need) exp_done = 1; else exp_err = 1;
`endif
    if (bad_idx >= 0) begin exp_done = 0; exp_err = 1; end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop_bit);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_and_check(input string tag, input logic [7:0] b[$], input int bad_idx,
                                 input bit exp_done, input bit exp_err);
    int lim, n, last_active;
    lim = (bad_idx >= 0) ? bad_idx + 1 : b.size();
    n = (b.size() >= 2) ? int'(b[0]) + 256 * int'(b[1]) : 0;
`ifdef RISCV_UPG_CHECKSUM_EN
    last_active = 2 + 4 * n - 1;
`else
    last_active = 2 + 4 * n - 2;
`endif
    for (int i = 0; i < lim; i++) begin
      send_byte(b[i], (i == bad_idx) ? 1'b0 : 1'b1);
      if (i >= 2 && i <= last_active && i != bad_idx && n >= 1 && n <= (1 << ADDR_W))
        check({tag, "_rst_active"}, 32'(upg_rst_o), 32'd0);
    end
    repeat (TO + 50) @(negedge clk);
    check({tag, "_done"},  32'(upg_done_o), 32'(exp_done));
    check({tag, "_err"},   32'(upg_err_o),  32'(exp_err));
    check({tag, "_rst"},   32'(upg_rst_o),  32'd1);
    check({tag, "_left"},  32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b[$], input int bad_idx);
    bit d, e;
    model_frame(b, bad_idx, d, e);
    drive_and_check(tag, b, bad_idx, d, e);
  endtask

  function automatic logic [7:0] xor_payload(input logic [7:0] b[$]);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < b.size(); i++) x = x ^ b[i];
    return x;
  endfunction

  initial begin
    logic [7:0] f[$];
    bit d, e;

    repeat (3) @(negedge clk);
    check("reset_rst",  32'(upg_rst_o),  32'd1);
    check("reset_wen",  32'(upg_wen_o),  32'd0);
    check("reset_adr",  32'(upg_adr_o),  32'd0);
    check("reset_dat",  upg_dat_o,       32'd0);
    check("reset_done", 32'(upg_done_o), 32'd0);
    check("reset_err",  32'(upg_err_o),  32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Two words, model pinned against hand-computed values.
    f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef RISCV_UPG_CHECKSUM_EN
    f.push_back(xor_payload(f));
`endif
    model_frame(f, -1, d, e);
    check("pin_nwr",  32'(exp_q.size()), 32'd2);
    check("pin_w0",   exp_q[0].dat, 32'h12345678);
    check("pin_a1",   32'(exp_q[1].adr), 32'd1);
    check("pin_w1",   exp_q[1].dat, 32'hDEADBEEF);
    check("pin_done", 32'(d), 32'd1);
    drive_and_check("two_words", f, -1, d, e);

    f = '{8'h00, 8'h00};
`ifdef RISCV_UPG_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    run_frame("zero_words", f, -1);

    // Short low pulse on an idle line must not disturb the done state.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_done", 32'(upg_done_o), 32'd1);
    check("glitch_err",  32'(upg_err_o),  32'd0);

    f = '{8'h01, 8'h00, 8'h55};
    run_frame("bad_stop", f, 2);

    f = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("timeout", f, -1);

    f = '{8'h01, 8'h40};
    run_frame("too_big", f, -1);

`ifdef RISCV_UPG_CHECKSUM_EN
    f = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    model_frame(f, -1, d, e);
    check("pin_csum_w", exp_q[0].dat, 32'h04030201);
    drive_and_check("csum_ok", f, -1, d, e);
    f = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame("csum_bad", f, -1);
`endif

    // Reset in the middle of a byte, after one word has been written.
    f = '{8'h02, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02};
    model_frame(f, -1, d, e);
    for (int i = 0; i < f.size(); i++) send_byte(f[i], 1'b1);
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rst",  32'(upg_rst_o),  32'd1);
    check("midrst_wen",  32'(upg_wen_o),  32'd0);
    check("midrst_adr",  32'(upg_adr_o),  32'd0);
    check("midrst_dat",  upg_dat_o,       32'd0);
    check("midrst_done", 32'(upg_done_o), 32'd0);
    check("midrst_err",  32'(upg_err_o),  32'd0);
    check("midrst_left", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (TO + 50) @(negedge clk);
    check("midrst_idle", 32'(upg_done_o | upg_err_o), 32'd0);

    // Randomised frames: sizes, data, truncation, bad stop bits, checksum errors.
    for (int t = 0; t < 8; t++) begin
      int n, bad_idx;
      n = $urandom_range(0, 3);
      f = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) f.push_back(8'($urandom));
`ifdef RISCV_UPG_CHECKSUM_EN
      f.push_back(xor_payload(f) ^ (($urandom_range(0, 3) == 0) ? 8'h5A : 8'h00));
`endif
      if ($urandom_range(0, 3) == 0 && f.size() > 2) begin
        int cut;
        cut = $urandom_range(1, f.size() - 1);
        while (f.size() > cut) void'(f.pop_back());
      end
      bad_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, f.size() - 1) : -1;
      run_frame($sformatf("rand%0d", t), f, bad_idx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_uart_programmer.md
Name: riscv_uart_programmer

Overview:
- UART-side writer that feeds the upg_* programming interface of the memory/IO bridge and cache.
- Receives a byte stream on a serial RX pin and assembles little-endian 32-bit words.
- Emits one-cycle write strobes with incrementing word addresses, then raises done.
- Holds programming reset deasserted only while a transfer is in progress.

Parameters:
- CLK_FREQ, 100000000, clk frequency in Hz.
- BAUD, 115200, serial bit rate; DIV = CLK_FREQ/BAUD (integer division), minimum 4.
- ADDR_W, 14, width of upg_adr_o in words.
- TIMEOUT_CYC, 2000000, idle cycles allowed between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high, sampled on the rising edge of clk
- rx  in  1  UART serial input; idles high; 8N1, LSB first
- upg_rst_o  out  1  1 = programmer idle/in reset; 0 = transfer active
- upg_wen_o  out  1  one-cycle write strobe
- upg_adr_o  out  ADDR_W  word address, valid with upg_wen_o
- upg_dat_o  out  32  write data, valid with upg_wen_o
- upg_done_o  out  1  level: last word of a frame has been written
- upg_err_o  out  1  sticky error flag

Behaviour:
- Reset values: upg_rst_o=1, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_err_o=0. rx synchroniser flops reset to 1.
- RX path: 2-FF synchroniser, then falling-edge start detect. Sample at DIV/2 into the start bit; if the line is high there, it is a false start and the receiver returns to idle. Data bits are sampled every DIV cycles. At the stop sample, a low line is a framing error: byte dropped, upg_err_o set, FSM goes to ERR. A good byte produces a one-cycle byte_valid.
- Frame format: 2-byte header N (word count, little-endian), then N*4 payload bytes, each word little-endian.
- FSM states: IDLE, HDR0, HDR1, DATA, DONE, ERR.
  - IDLE: upg_rst_o=1. First byte_valid moves to HDR1 with N[7:0] latched; upg_done_o cleared; upg_err_o cleared.
  - HDR1: latch N[15:8].
    - N==0: go to DONE.
    - N>2^ADDR_W: set err, go to ERR.
    - Otherwise go to DATA with upg_rst_o=0, adr=0, byte_idx=0.
  - DATA: bytes shift into word[8*byte_idx +: 8]. On the 4th byte, in the next cycle: upg_wen_o=1, upg_dat_o=word, upg_adr_o=current index; the index increments the cycle after the strobe. The strobe for the word that completes the frame, index N-1, is followed by DONE.
  - DONE: upg_done_o=1, upg_rst_o=1. A new byte_valid restarts as in IDLE.
  - ERR: upg_err_o=1, upg_rst_o=1, upg_done_o=0. A new byte_valid is treated as a new header byte 0.
- Timeout: in HDR1/DATA, a counter is reset on every byte_valid. When it reaches TIMEOUT_CYC, set err and go to ERR. Partial words are discarded and never written.
- Address width: the index counter is ADDR_W+1 bits internally so that N=2^ADDR_W completes without wrapping; upg_adr_o outputs the low ADDR_W bits.
- Simultaneous events: a byte completing on the same cycle the timeout expires counts as received.
- rst mid-byte or mid-frame returns to IDLE immediately. No write strobe is issued in the reset cycle.

Optional Feature:
- Macro RISCV_UPG_CHECKSUM_EN.
- Defined: after the payload, one extra byte is expected, equal to the XOR of all payload bytes. Words are written as they arrive. On a match, enter DONE; on a mismatch, set err and enter ERR with upg_done_o=0. N==0 also expects the checksum byte, which must be 0x00.
- Undefined: no checksum byte; DONE follows the last word directly.

Decomposition:
- riscv_defs.v gains: FSM state encodings (UPG_ST_IDLE..UPG_ST_ERR, 3 bits), UPG_HDR_BYTES=2, UPG_WORD_BYTES=4.
- Sub-module riscv_uart_rx: synchroniser, start/bit timing, 8N1 deserialiser. Outputs byte, byte_valid, frame_err.
- Top level holds the frame FSM, address/word assembly, timeout and checksum.

Test Plan (CLK_FREQ=16, BAUD=1, DIV=16, TIMEOUT_CYC=400):
- Send 02 00 78 56 34 12 EF BE AD DE → wen pulses: adr0/0x12345678, then adr1/0xDEADBEEF. upg_done_o=1 after the second pulse; upg_rst_o 0 during the frame.
- Send 00 00 → no wen, upg_done_o=1, upg_err_o=0.
- Header 01 00, then a byte with stop bit driven low → upg_err_o=1, no wen, upg_done_o=0.
- Header 02 00, then 4 bytes, then silence >400 cycles → one wen at adr0, then upg_err_o=1.
- A 4-cycle low glitch on idle rx → no byte_valid, state unchanged. Assert rst mid-payload → all outputs at reset values next cycle.
- With RISCV_UPG_CHECKSUM_EN: 01 00 01 02 03 04 04 → wen adr0/0x04030201, done=1. Same frame with checksum 05 → err=1, done=0.
